// File: rtl/safe_wrapper_boot_seq.sv
// Boot sequencer: programs the safe-wrapper control registers over the register bus,
// then polls the end-of-routine flag until it is set, a timeout expires, or an error occurs.

package safe_wrapper_boot_seq_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              valid;
  } reg_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              error;
    logic              ready;
  } reg_rsp_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BUS     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;
endpackage

module safe_wrapper_boot_seq
  import safe_wrapper_boot_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter logic [31:0] MASTER_CORE_OFF = 32'h0,
  parameter logic [31:0] SAFE_CONFIG_OFF = 32'h8,
  parameter logic [31:0] SAFE_MODE_OFF   = 32'h4,
  parameter logic [31:0] INIT_SYNC_OFF   = 32'h10,
  parameter logic [31:0] START_OFF       = 32'h14,
  parameter logic [31:0] END_SW_OFF      = 32'h18,
  parameter int unsigned POLL_GAP        = 4,
  parameter int unsigned TIMEOUT         = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [2:0] cfg_master_core_i,
  input  logic [1:0] cfg_safe_config_i,
  input  logic       cfg_safe_mode_i,
  output reg_req_t   reg_req_o,
  input  reg_rsp_t   reg_rsp_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [1:0] err_code_o
);

  localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
  localparam int unsigned GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

  localparam logic [31:0] ADDR_MC    = BASE_ADDR + MASTER_CORE_OFF;
  localparam logic [31:0] ADDR_CFG   = BASE_ADDR + SAFE_CONFIG_OFF;
  localparam logic [31:0] ADDR_MODE  = BASE_ADDR + SAFE_MODE_OFF;
  localparam logic [31:0] ADDR_SYNC  = BASE_ADDR + INIT_SYNC_OFF;
  localparam logic [31:0] ADDR_START = BASE_ADDR + START_OFF;
  localparam logic [31:0] ADDR_END   = BASE_ADDR + END_SW_OFF;

  typedef enum logic [3:0] {
    S_IDLE, S_W_MC, S_W_CFG, S_W_MODE, S_W_SYNC, S_W_START,
    S_POLL_RD, S_POLL_GAP, S_DONE, S_ERR
  } state_t;

  state_t             state_q, state_d;
  reg_req_t           req_q, req_d;
  logic [2:0]         mc_q, mc_d;
  logic [1:0]         cfg_q, cfg_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;

  logic               xfer_done;
  logic               bus_err;
  logic               fail;
  logic [1:0]         fail_code;
  logic [CNT_W-1:0]   cnt_inc;
  logic               tmo;
  logic               unused_rdata;

  assign unused_rdata = ^reg_rsp_i.rdata[DATA_W-1:1];

  // Next-state, error capture and registered bus request.
  always_comb begin
    state_d   = state_q;
    mc_d      = mc_q;
    cfg_d     = cfg_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    err_d     = err_q;
    code_d    = code_q;
    fail      = 1'b0;
    fail_code = ERR_NONE;
    req_d     = '0;

    xfer_done = req_q.valid && reg_rsp_i.ready;
    bus_err   = xfer_done && reg_rsp_i.error;
    cnt_inc   = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
    tmo       = (cnt_inc == CNT_W'(TIMEOUT));

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_W_MC;
          mc_d    = cfg_master_core_i;
          cfg_d   = cfg_safe_config_i;
          mode_d  = cfg_safe_mode_i;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
        end
      end
      S_W_MC, S_W_CFG, S_W_MODE, S_W_SYNC, S_W_START: begin
        if (xfer_done) begin
          if (bus_err) begin
            fail = 1'b1; fail_code = ERR_BUS;
          end else if (abort_i) begin
            fail = 1'b1; fail_code = ERR_ABORT;
          end else begin
            case (state_q)
              S_W_MC:   state_d = S_W_CFG;
              S_W_CFG:  state_d = S_W_MODE;
              S_W_MODE: state_d = S_W_SYNC;
              S_W_SYNC: state_d = S_W_START;
              default: begin
                state_d = S_POLL_RD;
                cnt_d   = '0;
              end
            endcase
          end
        end
      end
      S_POLL_RD: begin
        cnt_d = cnt_inc;
        if (xfer_done) begin
          if (bus_err) begin
            fail = 1'b1; fail_code = ERR_BUS;
          end else if (reg_rsp_i.rdata[0]) begin
            state_d = S_DONE;
          end else if (abort_i) begin
            fail = 1'b1; fail_code = ERR_ABORT;
          end else if (tmo) begin
            fail = 1'b1; fail_code = ERR_TIMEOUT;
          end else if (POLL_GAP == 0) begin
            state_d = S_POLL_RD;
          end else begin
            state_d = S_POLL_GAP;
            gap_d   = '0;
          end
        end
      end
      S_POLL_GAP: begin
        cnt_d = cnt_inc;
        if (abort_i) begin
          fail = 1'b1; fail_code = ERR_ABORT;
        end else if (tmo) begin
          fail = 1'b1; fail_code = ERR_TIMEOUT;
        end else if (gap_q == GAP_W'(GAP_LAST)) begin
          state_d = S_POLL_RD;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      code_d  = fail_code;
    end

    // Request fields follow the next state, so they only move on a completed handshake.
    case (state_d)
      S_W_MC:    begin req_d.addr = ADDR_MC;    req_d.wdata = {29'b0, mc_d};   end
      S_W_CFG:   begin req_d.addr = ADDR_CFG;   req_d.wdata = {30'b0, cfg_d};  end
      S_W_MODE:  begin req_d.addr = ADDR_MODE;  req_d.wdata = {31'b0, mode_d}; end
      S_W_SYNC:  begin req_d.addr = ADDR_SYNC;  req_d.wdata = 32'h1;           end
      S_W_START: begin req_d.addr = ADDR_START; req_d.wdata = 32'h1;           end
      S_POLL_RD: begin req_d.addr = ADDR_END;   req_d.valid = 1'b1;            end
      default:   req_d = '0;
    endcase
    if (state_d inside {S_W_MC, S_W_CFG, S_W_MODE, S_W_SYNC, S_W_START}) begin
      req_d.valid = 1'b1;
      req_d.write = 1'b1;
      req_d.wstrb = 4'hF;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      mc_q    <= '0;
      cfg_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      mc_q    <= mc_d;
      cfg_q   <= cfg_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign reg_req_o  = req_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule
